qerv_rf_dbg_ctrl: RTL and testbench
===================================

Name: qerv_rf_dbg_ctrl

Overview:
- Debug access controller for the register-file RAM. It sits between the rf_ram_if RAM-side port and serv_rf_ram inside the RF top level.
- It lets an external debug host read and write whole 32-bit GPRs and CSR slots.
- Before taking the RAM it halts the core through a halt handshake, then sequences the required RF_WIDTH-wide beats.
- At all other times it passes the core's RAM traffic through unchanged.

Parameters:
- RF_WIDTH, 8, RAM word width; must divide 32. BEATS = 32/RF_WIDTH.
- CSR_REGS, 4, CSR slots stored after x31 (0 or 4).
- RF_L2D, $clog2((32+CSR_REGS)*32/RF_WIDTH), RAM address width.

Ports:
- clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_dbg_req  in  1  host request, level, held until o_dbg_ack
- i_dbg_we  in  1  1 = write, 0 = read
- i_dbg_reg  in  6  register index; 0..31 GPR, 32..31+CSR_REGS CSR slot
- i_dbg_wdata  in  32  write data
- i_dbg_hold  in  1  keep core halted after ack (multi-access sessions)
- o_dbg_ack  out  1  one-cycle completion pulse
- o_dbg_err  out  1  valid with ack; index out of range
- o_dbg_rdata  out  32  read data, valid with ack, held until next ack
- o_cpu_halt  out  1  halt request to core
- i_cpu_halted  in  1  core is parked between instructions; RF idle
- i_cpu_waddr/i_cpu_wdata/i_cpu_wen/i_cpu_raddr/i_cpu_ren  in  RF_L2D/RF_WIDTH/1/RF_L2D/1  from rf_ram_if
- o_cpu_rdata  out  RF_WIDTH  to rf_ram_if
- o_ram_waddr/o_ram_wdata/o_ram_wen/o_ram_raddr/o_ram_ren  out  RF_L2D/RF_WIDTH/1/RF_L2D/1  to serv_rf_ram
- i_ram_rdata  in  RF_WIDTH  from serv_rf_ram, one-cycle registered read
- o_conflict  out  1  sticky: core accessed RAM while controller owned it

Behaviour:
- Reset (i_rst_n = 0 at a clock edge): state IDLE.
  - o_dbg_ack, o_dbg_err, o_cpu_halt and o_conflict are 0; o_dbg_rdata is 0.
  - RAM enables are not driven by the controller (passthrough).
  - Reset mid-transaction aborts it: no ack, halt drops, and a partial write stays partial.
- Address map: RAM address = reg*BEATS + beat. Beat 0 carries bits [RF_WIDTH-1:0]; beats ascend towards the MSBs.
- States: IDLE, HALT, RD, WR, ACK.
- IDLE, when i_dbg_req = 1:
  - reg >= 32+CSR_REGS: go to ACK with err = 1; no halt.
  - reg == 0: go to ACK. A read returns 0, a write is dropped, and no RAM access is made.
  - Otherwise: go to HALT and assert o_cpu_halt from the next cycle.
- HALT: wait with no timeout until i_cpu_halted is sampled 1, then go to RD or WR. If i_cpu_halted is already 1, HALT lasts exactly one cycle.
- RD: beat counter k runs 0..BEATS.
  - For k < BEATS: issue ren = 1 with raddr = base + k.
  - For k >= 1: capture i_ram_rdata into rdata slice k-1.
  - Lasts BEATS+1 cycles, then go to ACK.
- WR: for k = 0..BEATS-1 issue wen = 1 with waddr = base + k and wdata = slice k. Lasts BEATS cycles, then go to ACK.
- ACK: o_dbg_ack = 1 for one cycle, then IDLE.
  - o_cpu_halt stays 1 in IDLE while i_dbg_hold = 1; otherwise it drops on leaving ACK.
  - The host must drop i_dbg_req in the ack cycle; a req still high in IDLE starts a new transaction.
- Ownership: in RD/WR all o_ram_* come from the controller. In every other state o_ram_* = i_cpu_*. o_cpu_rdata = i_ram_rdata always.
- If i_cpu_ren or i_cpu_wen = 1 while in RD/WR: core traffic is discarded and o_conflict sets, staying set until reset.
- Latency with halted already 1 (BEATS = 4, req sampled at cycle 0):
  - read: ack in cycle 7.
  - write: ack in cycle 6.
  - err or reg 0: ack in cycle 1.
- i_dbg_we, i_dbg_reg and i_dbg_wdata are latched in IDLE on acceptance; later changes are ignored.

Decomposition:
- Package qerv_dbg_pkg holds:
  - the state enum;
  - the BEATS and NUM_REGS (32+CSR_REGS) derivation;
  - the address-compose function reg*BEATS+beat.
- No sub-module. The RAM port mux is inline; a separate 2:1 mux module adds nothing.

Test Plan:
- Passthrough: no req; drive core ren/raddr = 0x20 and wen/waddr = 0x21 with data 0xA5. RAM sees identical values the same cycle; o_cpu_rdata follows i_ram_rdata.
- Write then read x5 with halted tied 1, BEATS = 4:
  - write 0xDEADBEEF: wen pulses cycles 2..5 at addr 20..23 with data EF, BE, AD, DE; ack at cycle 6.
  - read back: ack at cycle 7 with rdata 0xDEADBEEF.
- Halt handshake: i_cpu_halted rises 10 cycles after o_cpu_halt. No RAM enable from the controller before then; ack exactly BEATS+2 cycles after halted is sampled (read).
- Edge indices:
  - reg 0 read: ack cycle 1, rdata 0, no ren.
  - reg 36 with CSR_REGS = 4: ack with err = 1, no halt.
  - reg 35: normal access at address 140..143.
- Session hold: i_dbg_hold = 1 across two reads; o_cpu_halt stays high between them and the second HALT lasts one cycle. After hold drops, halt falls the cycle after the final ack.
- Reset and conflict:
  - i_rst_n = 0 during WR beat 2: next cycle all outputs are 0 and state is IDLE.
  - Core wen asserted during RD: o_conflict = 1 and sticky until reset.

Source files
------------

// File: rtl/qerv_dbg_pkg.sv
// Shared types and helpers for the register-file debug access controller.
package qerv_dbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_RD,
    S_WR,
    S_ACK
  } dbg_state_e;

  // Number of RAM beats that make up one 32-bit register.
  function automatic int beats_of(input int rf_width);
    return 32 / rf_width;
  endfunction

  // GPRs x0..x31 followed by the CSR slots.
  function automatic int num_regs_of(input int csr_regs);
    return 32 + csr_regs;
  endfunction

  // RAM word address of a given beat of a register.
  function automatic int unsigned rf_addr(input int unsigned r,
                                          input int unsigned beat,
                                          input int unsigned beats);
    return r * beats + beat;
  endfunction

endpackage

// File: rtl/qerv_rf_dbg_ctrl.sv
// Debug access controller sitting between rf_ram_if and serv_rf_ram.
// Halts the core, then reads or writes a whole 32-bit register in
// RF_WIDTH-wide beats; passes core RAM traffic through otherwise.
module qerv_rf_dbg_ctrl
  import qerv_dbg_pkg::*;
#(
  parameter int RF_WIDTH = 8,
  parameter int CSR_REGS = 4,
  parameter int RF_L2D   = $clog2((32 + CSR_REGS) * 32 / RF_WIDTH)
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_dbg_req,
  input  logic                i_dbg_we,
  input  logic [5:0]          i_dbg_reg,
  input  logic [31:0]         i_dbg_wdata,
  input  logic                i_dbg_hold,
  output logic                o_dbg_ack,
  output logic                o_dbg_err,
  output logic [31:0]         o_dbg_rdata,
  output logic                o_cpu_halt,
  input  logic                i_cpu_halted,
  input  logic [RF_L2D-1:0]   i_cpu_waddr,
  input  logic [RF_WIDTH-1:0] i_cpu_wdata,
  input  logic                i_cpu_wen,
  input  logic [RF_L2D-1:0]   i_cpu_raddr,
  input  logic                i_cpu_ren,
  output logic [RF_WIDTH-1:0] o_cpu_rdata,
  output logic [RF_L2D-1:0]   o_ram_waddr,
  output logic [RF_WIDTH-1:0] o_ram_wdata,
  output logic                o_ram_wen,
  output logic [RF_L2D-1:0]   o_ram_raddr,
  output logic                o_ram_ren,
  input  logic [RF_WIDTH-1:0] i_ram_rdata,
  output logic                o_conflict
);

  localparam int BEATS    = beats_of(RF_WIDTH);
  localparam int NUM_REGS = num_regs_of(CSR_REGS);

  dbg_state_e  state, state_n;
  logic [5:0]  k;
  logic        we_q;
  logic [5:0]  reg_q;
  logic [31:0] wdata_q;
  logic [31:0] rbuf;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        halt_q;
  logic        conflict_q;

  logic        req_bad, req_zero;
  logic [RF_L2D-1:0] beat_addr;

  assign req_bad   = 32'(i_dbg_reg) >= NUM_REGS;
  assign req_zero  = i_dbg_reg == 6'd0;
  assign beat_addr = RF_L2D'(rf_addr(32'(reg_q), 32'(k), BEATS));

  assign o_cpu_rdata = i_ram_rdata;
  assign o_cpu_halt  = halt_q;
  assign o_conflict  = conflict_q;
  // Fresh read data is visible during the ack cycle, then held.
  assign o_dbg_rdata = (state == S_ACK) ? rbuf : rdata_q;
  assign o_dbg_err   = (state == S_ACK) & err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next state, ack and the RAM port ownership mux.
  always_comb begin
    state_n     = state;
    o_dbg_ack   = 1'b0;
    o_ram_waddr = i_cpu_waddr;
    o_ram_wdata = i_cpu_wdata;
    o_ram_wen   = i_cpu_wen;
    o_ram_raddr = i_cpu_raddr;
    o_ram_ren   = i_cpu_ren;
    case (state)
      S_IDLE: begin
        if (i_dbg_req) state_n = (req_bad || req_zero) ? S_ACK : S_HALT;
      end
      S_HALT: begin
        if (i_cpu_halted) state_n = we_q ? S_WR : S_RD;
      end
      S_RD: begin
        o_ram_waddr = '0;
        o_ram_wdata = '0;
        o_ram_wen   = 1'b0;
        o_ram_raddr = beat_addr;
        o_ram_ren   = 32'(k) < BEATS;
        if (32'(k) == BEATS) state_n = S_ACK;
      end
      S_WR: begin
        o_ram_waddr = beat_addr;
        o_ram_wdata = wdata_q[32'(k)*RF_WIDTH +: RF_WIDTH];
        o_ram_wen   = 1'b1;
        o_ram_raddr = '0;
        o_ram_ren   = 1'b0;
        if (32'(k) == BEATS - 1) state_n = S_ACK;
      end
      S_ACK: begin
        o_dbg_ack = 1'b1;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Request latch, beat counter, read assembly, halt and conflict tracking.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      k          <= '0;
      we_q       <= 1'b0;
      reg_q      <= '0;
      wdata_q    <= '0;
      rbuf       <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      halt_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          k <= '0;
          if (i_dbg_req) begin
            we_q    <= i_dbg_we;
            reg_q   <= i_dbg_reg;
            wdata_q <= i_dbg_wdata;
            err_q   <= req_bad;
            // x0 reads as zero without touching the RAM.
            if (req_zero && !i_dbg_we) rbuf <= '0;
          end
          if (i_dbg_req && !req_bad && !req_zero) halt_q <= 1'b1;
          else if (!i_dbg_hold)                   halt_q <= 1'b0;
        end
        S_HALT: k <= '0;
        S_RD: begin
          k <= k + 6'd1;
          // RAM read is registered: beat k-1 arrives while beat k is issued.
          if (k != 6'd0) rbuf[(32'(k)-1)*RF_WIDTH +: RF_WIDTH] <= i_ram_rdata;
          if (i_cpu_ren || i_cpu_wen) conflict_q <= 1'b1;
        end
        S_WR: begin
          k <= k + 6'd1;
          if (i_cpu_ren || i_cpu_wen) conflict_q <= 1'b1;
        end
        S_ACK: begin
          rdata_q <= rbuf;
          if (!i_dbg_hold) halt_q <= 1'b0;
        end
        default: k <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_qerv_rf_dbg_ctrl.sv
// Directed bench for qerv_rf_dbg_ctrl with default parameters (RF_WIDTH 8, 4 CSRs).
module tb_qerv_rf_dbg_ctrl;

  localparam int W = 8;
  localparam int L = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0, we = 1'b0, hold = 1'b0, halted = 1'b1;
  logic [5:0]    dreg = '0;
  logic [31:0]   wdata = '0;
  logic          ack, err, halt, conflict;
  logic [31:0]   rdata;
  logic [L-1:0]  cpu_waddr = '0, cpu_raddr = '0;
  logic [W-1:0]  cpu_wdata = '0;
  logic          cpu_wen = 1'b0, cpu_ren = 1'b0;
  logic [W-1:0]  cpu_rdata;
  logic [L-1:0]  ram_waddr, ram_raddr;
  logic [W-1:0]  ram_wdata;
  logic          ram_wen, ram_ren;
  logic [W-1:0]  ram_rdata, ram_q = '0, force_rd = '0;
  logic          force_en = 1'b0;

  logic [W-1:0]  mem [256];

  int n_chk = 0;
  int n_fail = 0;

  logic          rec_wen  [64];
  logic          rec_ren  [64];
  logic          rec_halt [64];
  logic [L-1:0]  rec_waddr[64];
  logic [L-1:0]  rec_raddr[64];
  logic [W-1:0]  rec_wdata[64];

  assign ram_rdata = force_en ? force_rd : ram_q;

  always #5 clk = ~clk;

  // Registered-read RAM model standing in for serv_rf_ram.
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_q <= mem[ram_raddr];
  end

  qerv_rf_dbg_ctrl dut (
    .clk(clk), .i_rst_n(rst_n),
    .i_dbg_req(req), .i_dbg_we(we), .i_dbg_reg(dreg), .i_dbg_wdata(wdata),
    .i_dbg_hold(hold), .o_dbg_ack(ack), .o_dbg_err(err), .o_dbg_rdata(rdata),
    .o_cpu_halt(halt), .i_cpu_halted(halted),
    .i_cpu_waddr(cpu_waddr), .i_cpu_wdata(cpu_wdata), .i_cpu_wen(cpu_wen),
    .i_cpu_raddr(cpu_raddr), .i_cpu_ren(cpu_ren), .o_cpu_rdata(cpu_rdata),
    .o_ram_waddr(ram_waddr), .o_ram_wdata(ram_wdata), .o_ram_wen(ram_wen),
    .o_ram_raddr(ram_raddr), .o_ram_ren(ram_ren), .i_ram_rdata(ram_rdata),
    .o_conflict(conflict)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction; cycle 0 is the edge that samples the request.
  task automatic txn(input logic twe, input logic [5:0] treg, input logic [31:0] twd,
                     input int hdelay, output int ack_c, output logic [31:0] rd,
                     output logic er);
    int hc;
    hc = -1; ack_c = -1; rd = 'x; er = 'x;
    for (int i = 0; i < 64; i++) begin
      rec_wen[i] = 0; rec_ren[i] = 0; rec_halt[i] = 0;
      rec_waddr[i] = 0; rec_raddr[i] = 0; rec_wdata[i] = 0;
    end
    we = twe; dreg = treg; wdata = twd; req = 1'b1;
    if (hdelay > 0) halted = 1'b0;
    for (int c = 1; c < 64; c++) begin
      tick();
      rec_wen[c] = ram_wen; rec_ren[c] = ram_ren; rec_halt[c] = halt;
      rec_waddr[c] = ram_waddr; rec_raddr[c] = ram_raddr; rec_wdata[c] = ram_wdata;
      if (hdelay > 0 && halt && hc < 0) hc = c;
      if (hdelay > 0 && hc >= 0 && c == hc + hdelay) halted = 1'b1;
      if (ack) begin
        ack_c = c; rd = rdata; er = err; req = 1'b0;
        break;
      end
    end
    req = 1'b0;
  endtask

  function automatic int count_en(input int lo, input int hi, input logic is_wr);
    int n = 0;
    for (int c = lo; c <= hi; c++) n += int'(is_wr ? rec_wen[c] : rec_ren[c]);
    return n;
  endfunction

  initial begin
    int          ac;
    logic [31:0] rd;
    logic        er;
    logic [31:0] exp_w;
    int          hcnt;

    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    tick(); tick();
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_halt", halt, 0);
    check("rst_conflict", conflict, 0);
    check("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    tick();

    // Passthrough of core traffic
    cpu_ren = 1; cpu_raddr = 8'h20; cpu_wen = 1; cpu_waddr = 8'h21; cpu_wdata = 8'hA5;
    force_en = 1; force_rd = 8'h3C;
    #1;
    check("pt_ren", ram_ren, 1);
    check("pt_raddr", ram_raddr, 8'h20);
    check("pt_wen", ram_wen, 1);
    check("pt_waddr", ram_waddr, 8'h21);
    check("pt_wdata", ram_wdata, 8'hA5);
    check("pt_cpu_rdata", cpu_rdata, 8'h3C);
    tick();
    cpu_ren = 0; cpu_wen = 0; cpu_raddr = 0; cpu_waddr = 0; cpu_wdata = 0; force_en = 0;
    tick();
    check("pt_no_conflict", conflict, 0);

    // Write x5, halted already high
    txn(1, 6'd5, 32'hDEADBEEF, 0, ac, rd, er);
    check("wr5_ack_cycle", 64'(ac), 6);
    check("wr5_err", er, 0);
    check("wr5_halt_c1", rec_halt[1], 1);
    check("wr5_wen_count", 64'(count_en(1, 6, 1'b1)), 4);
    exp_w = 32'hDEADBEEF;
    for (int b = 0; b < 4; b++) begin
      check($sformatf("wr5_wen_c%0d", b + 2), rec_wen[b + 2], 1);
      check($sformatf("wr5_waddr_c%0d", b + 2), rec_waddr[b + 2], 64'(20 + b));
      check($sformatf("wr5_wdata_c%0d", b + 2), rec_wdata[b + 2], 64'(exp_w[b*8 +: 8]));
    end
    tick();
    check("wr5_halt_drop", halt, 0);

    // Read back x5
    txn(0, 6'd5, 32'h0, 0, ac, rd, er);
    check("rd5_ack_cycle", 64'(ac), 7);
    check("rd5_rdata", rd, 32'hDEADBEEF);
    check("rd5_ren_count", 64'(count_en(1, 7, 1'b0)), 4);
    check("rd5_raddr_c2", rec_raddr[2], 20);
    check("rd5_raddr_c5", rec_raddr[5], 23);
    tick();
    check("rd5_rdata_held", rdata, 32'hDEADBEEF);

    // Halt handshake: halted rises 10 cycles after halt (cycle 11)
    txn(0, 6'd5, 32'h0, 10, ac, rd, er);
    check("hs_ack_cycle", 64'(ac), 17);
    check("hs_no_en_early", 64'(count_en(1, 11, 1'b0) + count_en(1, 11, 1'b1)), 0);
    check("hs_rdata", rd, 32'hDEADBEEF);
    tick();

    // x0 read
    txn(0, 6'd0, 32'h0, 0, ac, rd, er);
    check("r0_ack_cycle", 64'(ac), 1);
    check("r0_rdata", rd, 0);
    check("r0_err", er, 0);
    check("r0_no_ren", 64'(count_en(1, 1, 1'b0)), 0);
    tick();

    // Out-of-range index 36
    txn(0, 6'd36, 32'h0, 0, ac, rd, er);
    check("r36_ack_cycle", 64'(ac), 1);
    check("r36_err", er, 1);
    check("r36_no_halt", rec_halt[1], 0);
    tick();
    check("r36_err_gone", err, 0);

    // Highest CSR slot 35
    txn(1, 6'd35, 32'h12345678, 0, ac, rd, er);
    check("w35_ack_cycle", 64'(ac), 6);
    check("w35_waddr_c2", rec_waddr[2], 140);
    check("w35_waddr_c5", rec_waddr[5], 143);
    check("w35_wdata_c5", rec_wdata[5], 8'h12);
    tick();
    txn(0, 6'd35, 32'h0, 0, ac, rd, er);
    check("r35_ack_cycle", 64'(ac), 7);
    check("r35_rdata", rd, 32'h12345678);
    tick();

    // Session hold across two reads
    hold = 1;
    txn(0, 6'd5, 32'h0, 0, ac, rd, er);
    check("hold1_ack_cycle", 64'(ac), 7);
    tick();
    check("hold_idle_halt_a", halt, 1);
    tick();
    check("hold_idle_halt_b", halt, 1);
    hold = 0;
    txn(0, 6'd35, 32'h0, 0, ac, rd, er);
    check("hold2_ack_cycle", 64'(ac), 7);
    check("hold2_rdata", rd, 32'h12345678);
    check("hold2_halt_at_ack", rec_halt[7], 1);
    tick();
    check("hold2_halt_after", halt, 0);

    // Reset during WR beat 2 of x7
    we = 1; dreg = 6'd7; wdata = 32'h11223344; req = 1;
    tick(); tick(); tick(); tick();
    check("rstwr_wen_b2", ram_wen, 1);
    check("rstwr_waddr_b2", ram_waddr, 30);
    rst_n = 0; req = 0;
    tick();
    check("rstwr_ack", ack, 0);
    check("rstwr_err", err, 0);
    check("rstwr_halt", halt, 0);
    check("rstwr_rdata", rdata, 0);
    check("rstwr_wen", ram_wen, 0);
    check("rstwr_ren", ram_ren, 0);
    rst_n = 1;
    tick();
    txn(0, 6'd7, 32'h0, 0, ac, rd, er);
    check("rstwr_partial", rd, 32'h00223344);
    tick();

    // Core write during RD sets sticky conflict
    we = 0; dreg = 6'd5; req = 1;
    tick(); tick(); tick();
    cpu_wen = 1; cpu_waddr = 8'h55; cpu_wdata = 8'h77;
    #1;
    check("cf_blocked_wen", ram_wen, 0);
    tick();
    cpu_wen = 0; cpu_waddr = 0; cpu_wdata = 0;
    check("cf_set", conflict, 1);
    hcnt = 0;
    while (!ack && hcnt < 20) begin tick(); hcnt++; end
    check("cf_ack_seen", ack, 1);
    check("cf_rdata", rdata, 32'hDEADBEEF);
    req = 0;
    tick(); tick(); tick();
    check("cf_sticky", conflict, 1);
    check("cf_mem_untouched", mem[8'h55], 0);
    rst_n = 0;
    tick();
    check("cf_rst_clear", conflict, 0);
    rst_n = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
